symbol_spreading: RTL
=====================

# symbol_spreading

Downstream neighbour of `framing_encoding`. It consumes the serialized, whitened PHR/PSDU bit stream (`framing_encoding_out` / `framing_encoding_out_valid`) and packs it LSB-first into 4-bit data symbols. Each symbol is mapped to the 802.15.4 O-QPSK 32-chip PN sequence and presented as one parallel 32-bit chip word to the modulator. The block also flushes a partial final symbol and flags the end of each frame.

## Interface
Parameters:
- none; chip table and widths are fixed.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spreading_in`  in  1  serial data bit; connects to `framing_encoding_out`.
- `spreading_in_valid`  in  1  bit qualifier; connects to `framing_encoding_out_valid`. High for the whole frame, one bit per clock.
- `chip_out`  out  32  chip word; `chip_out[31]` = c0 (first chip) … `chip_out[0]` = c31.
- `chip_out_valid`  out  1  one-cycle strobe; `chip_out` is valid while this is high.
- `symbol_out`  out  4  symbol value behind the current `chip_out`.
- `symbol_count`  out  9  symbols emitted in the current frame, including the flushed one.
- `frame_end`  out  1  one-cycle pulse marking the frame boundary.

## Operation
- FSM has two states, IDLE and ACTIVE.
  - IDLE → ACTIVE: `spreading_in_valid`=1 is sampled. That bit is stored as bit0, `bit_cnt`←1 and `symbol_count`←0.
  - ACTIVE → IDLE: `spreading_in_valid`=0 is sampled.
- Packing in ACTIVE: each sampled valid bit is written to `nibble[bit_cnt]`, then `bit_cnt` increments modulo 4. The first bit received is the symbol LSB.
- On the edge that samples the 4th bit (`bit_cnt`==3 with valid), the block:
  - loads `symbol_out` with {bit, nibble[2:0]};
  - loads `chip_out` with `table[symbol]`;
  - sets `chip_out_valid`=1;
  - increments `symbol_count`, saturating at 511.
- Flush: when valid is sampled low in ACTIVE with `bit_cnt`≠0:
  - the missing high bits are zero-padded and that symbol is emitted, following the same load rules as the 4th-bit edge;
  - `frame_end`=1 on the same edge, so it coincides with the flush strobe.
- Valid sampled low in ACTIVE with `bit_cnt`==0: `frame_end`=1 only, with no chip strobe. It appears one cycle after the last full symbol's strobe.
- Chip table, written as MSB=c0:
  - Symbol 0 = 0xD9C3522E.
  - Symbol k (k=1..7) = symbol 0 rotated right by 4k bits. Symbol 1 = 0xED9C3522; symbol 7 = 0x9C3522ED.
  - Symbol 8+k = symbol k ^ 0x55555555 (odd chips inverted). Symbol 8 = 0x8C96077B.
- `chip_out` and `symbol_out` hold their last value between strobes. `symbol_count` holds after the frame ends and clears at the next frame start.
- Back-to-back frames need at least one low-valid cycle between them; one low cycle is sufficient. A valid bit sampled in the cycle right after `frame_end` starts a new frame normally.

## Timing
- Reset values: `chip_out`=0, `chip_out_valid`=0, `symbol_out`=0, `symbol_count`=0, `frame_end`=0. The FSM resets to IDLE with `bit_cnt`=0 and `nibble`=0.
- Latency: `chip_out_valid` rises at the same edge that samples the symbol's 4th (or flush) bit. The strobe is high for exactly one clock.
- Strobe spacing: at most one strobe per 4 clocks during a continuous frame. The flush strobe can follow the last full strobe 2–4 clocks later.
- No backpressure: the consumer must accept each chip word in its strobe cycle.
- Reset mid-frame: outputs go to reset values immediately (asynchronous). A pending partial nibble is discarded and no `frame_end` is produced.
- `spreading_in` is ignored whenever `spreading_in_valid`=0.

## Test plan
- Reset and idle: hold `reset_n`=0, then release with valid=0 for 10 clocks → all outputs stay 0 and no strobe occurs.
- Full byte: feed 0x07 LSB-first (1,1,1,0,0,0,0,0), then drop valid. Required response:
  - 4th-bit edge: strobe with `symbol_out`=7, `chip_out`=0x9C3522ED, `symbol_count`=1;
  - 8th-bit edge: strobe with `symbol_out`=0, `chip_out`=0xD9C3522E, `symbol_count`=2;
  - next clock: `frame_end` pulse with no strobe.
- All symbols: stream nibbles 0..15 (64 bits) → 16 strobes, each matching the table, e.g. symbol 8 = 0x8C96077B and symbol 1 = 0xED9C3522; `symbol_count`=16.
- Partial flush: 6 bits 1,0,1,1,1,0, then valid low. Required response:
  - first strobe: `symbol_out`=0xD;
  - flush strobe: `symbol_out`=1, `chip_out`=0xED9C3522, coincident with `frame_end`; `symbol_count`=2.
- Back-to-back frames separated by one low-valid cycle → `symbol_count` restarts at 1 on the second frame's first strobe, with no bits lost or merged between the frames.
- Reset pulse after 2 bits of a frame → outputs return to 0 immediately. After release, a new 4-bit frame 0xF yields `symbol_out`=15 with no stale bits.

Source files
------------

// File: rtl/symbol_spreading_if.sv
// Serial whitened-bit input and parallel 32-chip word output bundle for symbol_spreading.
interface symbol_spreading_if;
  logic        spreading_in;
  logic        spreading_in_valid;
  logic [31:0] chip_out;
  logic        chip_out_valid;
  logic [3:0]  symbol_out;
  logic [8:0]  symbol_count;
  logic        frame_end;

  modport master (
    output spreading_in, spreading_in_valid,
    input  chip_out, chip_out_valid, symbol_out, symbol_count, frame_end
  );

  modport slave (
    input  spreading_in, spreading_in_valid,
    output chip_out, chip_out_valid, symbol_out, symbol_count, frame_end
  );
endinterface

// File: rtl/symbol_spreading.sv
// Packs serial bits LSB-first into 4-bit symbols and spreads each to its 32-chip O-QPSK PN word.
// Chip word strobes on the edge sampling a symbol's 4th (or flush) bit; no backpressure.
module symbol_spreading (
  input logic              clk,
  input logic              reset_n,
  symbol_spreading_if.slave bus
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [31:0] C_SYM0    = 32'hD9C3522E;
  localparam logic [31:0] C_ODD_INV = 32'h55555555;
  localparam logic [8:0]  C_CNT_MAX = 9'h1FF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_bit_cnt;
  logic [1:0]  w_bit_cnt_nxt;
  logic [3:0]  r_nibble;
  logic [3:0]  w_nibble_nxt;
  logic [3:0]  w_nibble_set;
  logic        w_emit;
  logic [3:0]  w_sym;
  logic        w_fend;
  logic        w_clr_cnt;

  logic [31:0] r_chip;
  logic        r_chip_vld;
  logic [3:0]  r_sym;
  logic [8:0]  r_sym_cnt;
  logic        r_fend;

  // Symbols 1..7 are nibble rotations of symbol 0; the upper half inverts the odd chips.
  function automatic logic [31:0] f_chip(input logic [3:0] sym);
    logic [63:0] w_dbl;
    logic [31:0] w_rot;
    w_dbl = {C_SYM0, C_SYM0} >> {sym[2:0], 2'b00};
    w_rot = w_dbl[31:0];
    return sym[3] ? (w_rot ^ C_ODD_INV) : w_rot;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_nibble_nxt  = r_nibble;
    w_emit        = 1'b0;
    w_sym         = r_nibble;
    w_fend        = 1'b0;
    w_clr_cnt     = 1'b0;
    w_nibble_set  = r_nibble | ({3'b000, bus.spreading_in} << r_bit_cnt);

    case (r_state)
      S_IDLE: begin
        if (bus.spreading_in_valid) begin
          w_state_nxt   = S_ACTIVE;
          w_nibble_nxt  = {3'b000, bus.spreading_in};
          w_bit_cnt_nxt = 2'd1;
          w_clr_cnt     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (bus.spreading_in_valid) begin
          w_bit_cnt_nxt = r_bit_cnt + 2'd1;
          if (r_bit_cnt == 2'd3) begin
            w_emit       = 1'b1;
            w_sym        = w_nibble_set;
            w_nibble_nxt = 4'd0;
          end else begin
            w_nibble_nxt = w_nibble_set;
          end
        end else begin
          // Nibble is cleared after every emit, so unwritten high bits are already zero-padded.
          w_state_nxt   = S_IDLE;
          w_fend        = 1'b1;
          w_bit_cnt_nxt = 2'd0;
          w_nibble_nxt  = 4'd0;
          w_emit        = (r_bit_cnt != 2'd0);
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = 2'd0;
        w_nibble_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 2'd0;
      r_nibble  <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_nibble  <= w_nibble_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chip     <= 32'd0;
      r_chip_vld <= 1'b0;
      r_sym      <= 4'd0;
      r_sym_cnt  <= 9'd0;
      r_fend     <= 1'b0;
    end else begin
      r_chip_vld <= w_emit;
      r_fend     <= w_fend;
      if (w_emit) begin
        r_sym  <= w_sym;
        r_chip <= f_chip(w_sym);
        if (r_sym_cnt != C_CNT_MAX) begin
          r_sym_cnt <= r_sym_cnt + 9'd1;
        end
      end else if (w_clr_cnt) begin
        r_sym_cnt <= 9'd0;
      end
    end
  end

  assign bus.chip_out       = r_chip;
  assign bus.chip_out_valid = r_chip_vld;
  assign bus.symbol_out     = r_sym;
  assign bus.symbol_count   = r_sym_cnt;
  assign bus.frame_end      = r_fend;

endmodule
